branch_predictor: RTL and testbench

//  Fetch-side partner of the execute-stage branch unit. Predicts next PC in fetch
//  via direct-mapped BTB + 2-bit saturating counters. Consumes the resolved take/dest

---
 rtl/branch_predictor_pkg.sv | 33 +++
 rtl/branch_predictor_if.sv | 35 +++
 rtl/bp_ctr2.sv | 19 +
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants, resolve payload and helpers for the fetch-side branch predictor.
// Optional performance counters are enabled with the BP_PERF_EN macro (see branch_predictor).
package branch_predictor_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] BP_CTR_SNT = 2'b00;
  localparam logic [1:0] BP_CTR_WNT = 2'b01;
  localparam logic [1:0] BP_CTR_WT  = 2'b10;
  localparam logic [1:0] BP_CTR_ST  = 2'b11;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Resolved control-flow instruction as seen from execute
  typedef struct packed {
    logic            valid;
    logic            is_cond;
    logic [XLEN-1:0] pc;
    logic            take;
    logic [XLEN-1:0] dest;
    logic            pred_take;
    logic [XLEN-1:0] pred_pc;
  } bp_resolve_t;

  function automatic logic [XLEN-1:0] bp_next_pc(input bp_resolve_t r);
    return r.take ? r.dest : r.pc + PC_STEP;
  endfunction

  function automatic logic bp_mispredict(input bp_resolve_t r);
    return r.valid & ((r.take != r.pred_take) | (r.take & (r.dest != r.pred_pc)));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolve and redirect signals between the pipeline and the predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            f_pred_take;
  logic [XLEN-1:0] f_pred_pc;

  logic            r_valid;
  logic            r_is_cond;
  logic [XLEN-1:0] r_pc;
  logic            r_take;
  logic [XLEN-1:0] r_dest;
  logic            r_pred_take;
  logic [XLEN-1:0] r_pred_pc;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  // Pipeline side: issues lookups and resolves, consumes predictions and redirects
  modport master (
    output f_valid, f_pc,
    output r_valid, r_is_cond, r_pc, r_take, r_dest, r_pred_take, r_pred_pc,
    input  f_pred_take, f_pred_pc, redirect, redirect_pc
  );

  // Predictor side
  modport slave (
    input  f_valid, f_pc,
    input  r_valid, r_is_cond, r_pc, r_take, r_dest, r_pred_take, r_pred_pc,
    output f_pred_take, f_pred_pc, redirect, redirect_pc
  );

endinterface

// File: rtl/bp_ctr2.sv
// 2-bit saturating taken/not-taken counter next-state logic.
module bp_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       take,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (take) begin
      if (ctr != BP_CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: 0-latency fetch lookup, execute-side training, redirect.
// Define BP_PERF_EN to add the perf_lookups / perf_mispred counter outputs.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  branch_predictor_if.slave bp
`ifdef BP_PERF_EN
  ,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_mispred
`endif
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned TAG_LO  = IDX_W + 2;
  localparam int unsigned TAG_HI  = TAG_LO + TAG_W - 1;

  logic             tab_valid [ENTRIES];
  logic [TAG_W-1:0] tab_tag   [ENTRIES];
  logic [XLEN-1:0]  tab_tgt   [ENTRIES];
  logic [1:0]       tab_ctr   [ENTRIES];

  // Fetch lookup: reads pre-update table contents, no bypass from the resolve port
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_take;

  assign f_idx  = bp.f_pc[TAG_LO-1:IDX_LO];
  assign f_tag  = bp.f_pc[TAG_HI:TAG_LO];
  assign f_hit  = bp.f_valid & tab_valid[f_idx] & (tab_tag[f_idx] == f_tag);
  assign f_take = f_hit & tab_ctr[f_idx][1];

  assign bp.f_pred_take = f_take;
  assign bp.f_pred_pc   = f_take ? tab_tgt[f_idx] : bp.f_pc + PC_STEP;

  bp_resolve_t res;

  assign res = '{
    valid:     bp.r_valid,
    is_cond:   bp.r_is_cond,
    pc:        bp.r_pc,
    take:      bp.r_take,
    dest:      bp.r_dest,
    pred_take: bp.r_pred_take,
    pred_pc:   bp.r_pred_pc
  };

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [1:0]       ctr_sat;
  logic [1:0]       ctr_upd;
  logic             upd_hit;
  logic             upd_alloc;
  logic             mispred;
  logic [XLEN-1:0]  npc;

  assign r_idx = res.pc[TAG_LO-1:IDX_LO];
  assign r_tag = res.pc[TAG_HI:TAG_LO];
  assign r_hit = tab_valid[r_idx] & (tab_tag[r_idx] == r_tag);

  bp_ctr2 u_ctr2 (
    .ctr      (tab_ctr[r_idx]),
    .take     (res.take),
    .ctr_next (ctr_sat)
  );

  // Unconditional jumps always pin the counter to strongly taken
  assign ctr_upd   = res.is_cond ? ctr_sat : BP_CTR_ST;
  assign upd_hit   = res.valid & r_hit;
  assign upd_alloc = res.valid & res.take & ~r_hit;
  assign mispred   = bp_mispredict(res);
  assign npc       = bp_next_pc(res);

  // Table training; a taken miss replaces the entry as weakly taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tab_valid[i] <= 1'b0;
        tab_tag[i]   <= '0;
        tab_tgt[i]   <= '0;
        tab_ctr[i]   <= BP_CTR_WNT;
      end
    end else if (upd_alloc) begin
      tab_valid[r_idx] <= 1'b1;
      tab_tag[r_idx]   <= r_tag;
      tab_tgt[r_idx]   <= res.dest;
      tab_ctr[r_idx]   <= BP_CTR_WT;
    end else if (upd_hit) begin
      if (res.take) tab_tgt[r_idx] <= res.dest;
      tab_ctr[r_idx] <= ctr_upd;
    end
  end

  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  // Redirect is a one-cycle pulse; the corrected PC is held until the next mispredict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mispred;
      if (mispred) redirect_pc_q <= npc;
    end
  end

  assign bp.redirect    = redirect_q;
  assign bp.redirect_pc = redirect_pc_q;

`ifdef BP_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lookups <= '0;
      perf_mispred <= '0;
    end else begin
      if (bp.f_valid) perf_lookups <= perf_lookups + 32'd1;
      if (mispred)    perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table plus randomized traffic checked against a table-level reference model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned N_VEC   = 15;
  localparam int unsigned N_RAND  = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp_if();

`ifdef BP_PERF_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispred;
`endif

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
`ifdef BP_PERF_EN
    ,
    .perf_lookups (perf_lookups),
    .perf_mispred (perf_mispred)
`endif
  );

  typedef struct {
    bit          f_valid;
    logic [31:0] f_pc;
    bit          r_valid;
    bit          r_is_cond;
    logic [31:0] r_pc;
    bit          r_take;
    logic [31:0] r_dest;
    bit          r_pred_take;
    logic [31:0] r_pred_pc;
    bit          exp_take;
    logic [31:0] exp_pc;
    bit          exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: per-index entry with an integer counter 0..3
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_redirect;
  logic [31:0] m_redirect_pc;
  int unsigned m_lookups;
  int unsigned m_mispred;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> (IDX_W + 2)) % (1 << TAG_W);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_redirect    = 1'b0;
    m_redirect_pc = '0;
    m_lookups     = 0;
    m_mispred     = 0;
  endfunction

  function automatic void model_predict(input bit fv, input logic [31:0] pc,
                                        output bit take, output logic [31:0] npc);
    int unsigned i;
    bit hit;
    i    = idx_of(pc);
    hit  = fv && m_valid[i] && (m_tag[i] == tag_of(pc));
    take = hit && (m_ctr[i] >= 2);
    npc  = take ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_resolve(input vec_t v);
    int unsigned i;
    bit hit;
    bit mis;
    if (v.f_valid) m_lookups++;
    if (!v.r_valid) begin
      m_redirect = 1'b0;
      return;
    end
    mis = (v.r_take != v.r_pred_take) || (v.r_take && (v.r_dest != v.r_pred_pc));
    m_redirect = mis;
    if (mis) begin
      m_redirect_pc = v.r_take ? v.r_dest : v.r_pc + 32'd4;
      m_mispred++;
    end
    i   = idx_of(v.r_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(v.r_pc));
    if (hit) begin
      if (v.r_take) m_tgt[i] = v.r_dest;
      if (!v.r_is_cond)  m_ctr[i] = 3;
      else if (v.r_take) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end else if (v.r_take) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(v.r_pc);
      m_tgt[i]   = v.r_dest;
      m_ctr[i]   = 2;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bp_if.f_valid     = v.f_valid;
    bp_if.f_pc        = v.f_pc;
    bp_if.r_valid     = v.r_valid;
    bp_if.r_is_cond   = v.r_is_cond;
    bp_if.r_pc        = v.r_pc;
    bp_if.r_take      = v.r_take;
    bp_if.r_dest      = v.r_dest;
    bp_if.r_pred_take = v.r_pred_take;
    bp_if.r_pred_pc   = v.r_pred_pc;
  endtask

  // One clock: drive at negedge, check lookup before the edge, redirect after it
  task automatic step(input vec_t v, input bit use_table, input string tag);
    bit          mt;
    logic [31:0] mpc;
    @(negedge clk);
    drive(v);
    #1;
    model_predict(v.f_valid, v.f_pc, mt, mpc);
    check({tag, ".f_pred_take"}, 32'(bp_if.f_pred_take), use_table ? 32'(v.exp_take) : 32'(mt));
    check({tag, ".f_pred_pc"}, bp_if.f_pred_pc, use_table ? v.exp_pc : mpc);
    @(posedge clk);
    model_resolve(v);
    #1;
    check({tag, ".redirect"}, 32'(bp_if.redirect), use_table ? 32'(v.exp_redir) : 32'(m_redirect));
    check({tag, ".redirect_pc"}, bp_if.redirect_pc, use_table ? v.exp_rpc : m_redirect_pc);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(9) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'(($urandom_range(3) << (IDX_W + 2)) | ($urandom_range(7) << 2));
  endfunction

  vec_t vecs [N_VEC];
  vec_t v;

  initial begin
    //         fv    f_pc           rv    cond  r_pc           take  dest           ptake ppc            etake epc            eredir erpc
    vecs[0]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h104,       1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h100,       1'b1, 32'h200,       1'b0, 32'h104,       1'b0, 32'h104,       1'b1, 32'h200};
    vecs[2]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h200};
    vecs[3]  = '{1'b0, 32'h100,      1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h104,       1'b1, 32'h104};
    vecs[4]  = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0, 32'h104,       1'b0, 32'h104,       1'b0, 32'h104};
    vecs[5]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h104,       1'b0, 32'h104};
    vecs[6]  = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h100,       1'b1, 32'h300,       1'b1, 32'h200,       1'b0, 32'h104,       1'b1, 32'h300};
    vecs[7]  = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h100,       1'b1, 32'h300,       1'b0, 32'h104,       1'b0, 32'h104,       1'b1, 32'h300};
    vecs[8]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h300,       1'b0, 32'h300};
    vecs[9]  = '{1'b1, 32'h100,      1'b1, 1'b0, 32'h200,       1'b1, 32'h500,       1'b0, 32'h204,       1'b1, 32'h300,       1'b1, 32'h500};
    vecs[10] = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h104,       1'b0, 32'h500};
    vecs[11] = '{1'b1, 32'h200,      1'b1, 1'b0, 32'h200,       1'b1, 32'h600,       1'b1, 32'h500,       1'b1, 32'h500,       1'b1, 32'h600};
    vecs[12] = '{1'b1, 32'h200,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h600,       1'b0, 32'h600};
    vecs[13] = '{1'b0, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hFFFFFFFC,  1'b0, 32'h0,         1'b1, 32'h1234,      1'b0, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};

    rst = 1'b1;
    v = '{default: '0};
    drive(v);
    repeat (2) @(negedge clk);
    check("reset.redirect", 32'(bp_if.redirect), 32'd0);
    check("reset.redirect_pc", bp_if.redirect_pc, 32'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < int'(N_VEC); i++) step(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Mid-stream reset with a redirect pending
    v = '{default: '0};
    v.f_valid = 1'b1; v.f_pc = 32'h200;
    v.r_valid = 1'b1; v.r_is_cond = 1'b1; v.r_pc = 32'h200; v.r_take = 1'b1;
    v.r_dest = 32'h700; v.r_pred_take = 1'b0; v.r_pred_pc = 32'h204;
    step(v, 1'b0, "prerst");
    check("prerst.pending", 32'(bp_if.redirect), 32'd1);
    #1 rst = 1'b1;
    v = '{default: '0};
    v.f_valid = 1'b1; v.f_pc = 32'h200;
    drive(v);
    #1;
    check("midrst.redirect", 32'(bp_if.redirect), 32'd0);
    check("midrst.redirect_pc", bp_if.redirect_pc, 32'd0);
    check("midrst.f_pred_take", 32'(bp_if.f_pred_take), 32'd0);
    check("midrst.f_pred_pc", bp_if.f_pred_pc, 32'h204);
    bp_if.f_pc = 32'h100;
    #1;
    check("midrst.alias_miss", bp_if.f_pred_pc, 32'h104);
`ifdef BP_PERF_EN
    check("midrst.perf_lookups", perf_lookups, 32'd0);
    check("midrst.perf_mispred", perf_mispred, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Ten lookups, two of the resolves mispredict
    for (int i = 0; i < 10; i++) begin
      v = '{default: '0};
      v.f_valid = 1'b1; v.f_pc = 32'(i * 4);
      if (i == 0 || i == 5) begin
        v.r_valid = 1'b1; v.r_is_cond = 1'b1; v.r_pc = 32'(i * 4 + 32'h40);
        v.r_take = 1'b1; v.r_dest = 32'h800; v.r_pred_take = 1'b0; v.r_pred_pc = 32'h0;
      end
      step(v, 1'b0, $sformatf("perf%0d", i));
    end
`ifdef BP_PERF_EN
    check("perf.lookups", perf_lookups, 32'd10);
    check("perf.mispred", perf_mispred, 32'd2);
`endif

    for (int n = 0; n < int'(N_RAND); n++) begin
      bit          pt;
      logic [31:0] ppc;
      v = '{default: '0};
      v.f_valid   = 1'($urandom_range(3) != 0);
      v.f_pc      = rand_pc();
      v.r_valid   = 1'($urandom_range(3) != 0);
      v.r_is_cond = 1'($urandom_range(4) != 0);
      v.r_pc      = rand_pc();
      v.r_take    = 1'($urandom_range(1));
      v.r_dest    = rand_pc();
      if ($urandom_range(1) == 1) begin
        model_predict(1'b1, v.r_pc, pt, ppc);
      end else begin
        pt  = 1'($urandom_range(1));
        ppc = rand_pc();
      end
      v.r_pred_take = pt;
      v.r_pred_pc   = ppc;
      step(v, 1'b0, $sformatf("rand%0d", n));
    end
`ifdef BP_PERF_EN
    check("rand.perf_lookups", perf_lookups, 32'(m_lookups));
    check("rand.perf_mispred", perf_mispred, 32'(m_mispred));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
